// File: rtl/led_matrix_pkg.sv
// -----------------------------------------------------------------------------
// led_matrix_pkg
//   Shared constants, row types and glyph helpers for the LED matrix scroller.
//
//   DEFAULT_SIZE : default matrix edge length.
//   MAX_SIZE     : widest matrix the helpers support (32).
//   glyph_row_t  : one row of the default-size matrix.
//   wide_row_t   : one row at MAX_SIZE width. The helpers work at this width
//                  and the caller keeps the low SIZE bits.
//   glyph()      : glyph ROM. Out-of-range indices read as glyph 0 (blank).
//   rotl()       : circular left rotate within the low 'size' bits.
// -----------------------------------------------------------------------------
package led_matrix_pkg;

    localparam int DEFAULT_SIZE = 16;
    localparam int MAX_SIZE     = 32;

    typedef logic [DEFAULT_SIZE-1:0] glyph_row_t;
    typedef logic [MAX_SIZE-1:0]     wide_row_t;

    // Ones in the low 'size' bits.
    function automatic wide_row_t size_mask(input int size);
        if (size >= MAX_SIZE) return '1;
        return (wide_row_t'(1) << size) - wide_row_t'(1);
    endfunction

    // Bit size-1 is the leftmost column.
    //   0 blank, 1 diagonal, 2 all on, 3 checkerboard, 4 box outline,
    //   5 left half lit, 6 two-row horizontal stripes, 7 anti-diagonal.
    function automatic wide_row_t glyph(input int idx, input int row,
                                        input int size, input int num_chars);
        wide_row_t mask;
        wide_row_t alt;
        wide_row_t r;
        mask = size_mask(size);
        // Alternating bits with the leftmost column lit.
        alt  = 32'hAAAA_AAAA >> (MAX_SIZE - size);
        r    = '0;
        if (idx >= 0 && idx < num_chars) begin
            case (idx)
                1:       r = wide_row_t'(1) << (size - 1 - row);
                2:       r = mask;
                3:       r = (row % 2 == 0) ? alt : (alt >> 1);
                4:       r = (row == 0 || row == size - 1) ? mask
                           : ((wide_row_t'(1) << (size - 1)) | wide_row_t'(1));
                5:       r = mask & ~(mask >> (size / 2));
                6:       r = ((row / 2) % 2 == 0) ? mask : '0;
                7:       r = wide_row_t'(1) << row;
                default: r = '0;
            endcase
        end
        return r & mask;
    endfunction

    function automatic wide_row_t rotl(input wide_row_t val, input int amt,
                                       input int size);
        wide_row_t mask;
        wide_row_t v;
        int        a;
        mask = size_mask(size);
        v    = val & mask;
        a    = amt % size;
        if (a == 0) return v;
        return ((v << a) | (v >> (size - a))) & mask;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// -----------------------------------------------------------------------------
// led_scan_timer
//   Row scan timebase. A prescaler counts 0..SCAN_DIV-1 and raises 'tick' in
//   the cycle it wraps. On each tick the row index advances and wraps from
//   SIZE-1 to 0. 'frame_boundary' marks the tick that wraps the row.
//   With en low, the prescaler and the row hold, and no tick is produced.
//
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : advance enable
//   tick            : one-cycle strobe, last prescaler cycle of a row slot
//   row             : current row index
//   frame_boundary  : tick that wraps the row back to 0
// -----------------------------------------------------------------------------
module led_scan_timer #(
    parameter  int SIZE     = 16,
    parameter  int SCAN_DIV = 1000,
    localparam int RW       = $clog2(SIZE),
    localparam int PW       = $clog2(SCAN_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          tick,
    output logic [RW-1:0] row,
    output logic          frame_boundary
);

    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SIZE - 1);

    logic [PW-1:0] pre;
    logic [RW-1:0] row_next;

    assign tick           = en && (pre == PRE_LAST);
    assign frame_boundary = tick && (row == ROW_LAST);

    always_comb begin
        row_next = row;
        if (tick) row_next = (row == ROW_LAST) ? '0 : row + RW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            row <= '0;
        end else if (en) begin
            pre <= tick ? '0 : pre + PW'(1);
            row <= row_next;
        end
    end

endmodule

// File: rtl/led_matrix_scroller.sv
// -----------------------------------------------------------------------------
// led_matrix_scroller
//   Time-multiplexed SIZE x SIZE LED matrix driver. Each row slot shows one
//   row of the current glyph. The row can be circularly rotated by a scroll
//   offset. Glyph changes and scroll steps apply only at frame boundaries, so
//   a frame is never drawn with mixed content.
//
//   Optional feature macro: LED_MATRIX_BLINK_EN. It adds the blink_en input
//   and the BLINK_FRAMES parameter. While blink_en is high, a visibility flag
//   toggles every BLINK_FRAMES frames. When the flag is low, col_data is
//   blanked and row_sel keeps scanning.
//
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     en          : display enable. Low blanks the outputs and freezes the
//                   scan and the scroll state.
//     char_sel    : requested glyph index. Indices >= NUM_CHARS show blank.
//     load        : single-cycle strobe that captures char_sel as pending.
//                   There is no back-pressure: every strobe is accepted.
//                   The last strobe before a frame boundary wins.
//     scroll_en   : advance the scroll offset every SCROLL_FRAMES frames
//     scroll_dir  : 0 = left (offset + 1), 1 = right (offset - 1)
//     row_sel     : one-hot row strobe (registered)
//     col_data    : column data for the strobed row. Bit SIZE-1 is the
//                   leftmost column.
//     frame_done  : one-cycle pulse that arrives with the row-0 update
//     pending     : a loaded glyph is waiting for the next frame boundary
// -----------------------------------------------------------------------------
module led_matrix_scroller
    import led_matrix_pkg::*;
#(
    parameter  int SIZE          = DEFAULT_SIZE,
    parameter  int NUM_CHARS     = 8,
    parameter  int SCAN_DIV      = 1000,
    parameter  int SCROLL_FRAMES = 4,
`ifdef LED_MATRIX_BLINK_EN
    parameter  int BLINK_FRAMES  = 32,
`endif
    localparam int CW            = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [CW-1:0]   char_sel,
    input  logic            load,
    input  logic            scroll_en,
    input  logic            scroll_dir,
`ifdef LED_MATRIX_BLINK_EN
    input  logic            blink_en,
`endif
    output logic [SIZE-1:0] row_sel,
    output logic [SIZE-1:0] col_data,
    output logic            frame_done,
    output logic            pending
);

    localparam int OW = $clog2(SIZE);
    localparam int FW = $clog2(SCROLL_FRAMES + 1);
    localparam logic [OW-1:0] OFF_LAST   = OW'(SIZE - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_FRAMES - 1);

    logic          tick;
    logic          frame_boundary;
    logic [OW-1:0] row;
    logic [OW-1:0] row_next;

    logic [CW-1:0] cur_char,  pend_char, cur_next;
    logic [OW-1:0] offset,    off_next;
    logic [FW-1:0] fcnt,      fcnt_next;
    logic          swap;
    logic          visible_next;

    wide_row_t       glyph_w;
    wide_row_t       rot_w;
    logic [SIZE-1:0] row_data;

    led_scan_timer #(
        .SIZE     (SIZE),
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .tick           (tick),
        .row            (row),
        .frame_boundary (frame_boundary)
    );

    // Row that the timer holds after this edge. The outputs are registered
    // from next-state values so the displayed row, glyph and offset always
    // change together, one cycle after the tick.
    always_comb begin
        row_next = row;
        if (frame_boundary) row_next = '0;
        else if (tick)      row_next = row + OW'(1);
    end

    assign swap = frame_boundary && pending;

    // A pending glyph swap takes precedence over a scroll step at the same
    // boundary. The swap restarts scrolling from offset 0.
    always_comb begin
        cur_next  = cur_char;
        off_next  = offset;
        fcnt_next = fcnt;
        if (swap) begin
            cur_next  = pend_char;
            off_next  = '0;
            fcnt_next = '0;
        end else if (frame_boundary && scroll_en) begin
            if (fcnt == FRAME_LAST) begin
                fcnt_next = '0;
                if (!scroll_dir) off_next = (offset == OFF_LAST) ? '0 : offset + OW'(1);
                else             off_next = (offset == '0) ? OFF_LAST : offset - OW'(1);
            end else begin
                fcnt_next = fcnt + FW'(1);
            end
        end
    end

`ifdef LED_MATRIX_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] bcnt, bcnt_next;
    logic          visible;

    always_comb begin
        bcnt_next    = bcnt;
        visible_next = visible;
        if (!blink_en) begin
            bcnt_next    = '0;
            visible_next = 1'b1;
        end else if (frame_boundary) begin
            if (bcnt == BLINK_LAST) begin
                bcnt_next    = '0;
                visible_next = ~visible;
            end else begin
                bcnt_next = bcnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt    <= '0;
            visible <= 1'b1;
        end else begin
            bcnt    <= bcnt_next;
            visible <= visible_next;
        end
    end
`else
    assign visible_next = 1'b1;
`endif

    always_comb begin
        glyph_w  = glyph(int'(cur_next), int'(row_next), SIZE, NUM_CHARS);
        rot_w    = rotl(glyph_w, int'(off_next), SIZE);
        row_data = SIZE'(rot_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sel    <= '0;
            col_data   <= '0;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            cur_char   <= '0;
            pend_char  <= '0;
            offset     <= '0;
            fcnt       <= '0;
        end else begin
            // cur_next only differs from cur_char on a boundary, and a
            // boundary needs en, so this is safe to load every cycle.
            cur_char <= cur_next;
            if (en) begin
                offset     <= off_next;
                fcnt       <= fcnt_next;
                row_sel    <= SIZE'(1) << row_next;
                col_data   <= visible_next ? row_data : '0;
                frame_done <= frame_boundary;
            end else begin
                row_sel    <= '0;
                col_data   <= '0;
                frame_done <= 1'b0;
            end
            // A load that lands on a swap boundary becomes the next pending
            // glyph, while the older pending value is the one shown.
            if (load) begin
                pend_char <= char_sel;
                pending   <= 1'b1;
            end else if (swap) begin
                pending   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scroller.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scroller
//   Bench for led_matrix_scroller with SIZE=16, NUM_CHARS=6, SCAN_DIV=4 and
//   SCROLL_FRAMES=2, so one frame is 64 cycles. When the design is built with
//   LED_MATRIX_BLINK_EN, the bench also uses BLINK_FRAMES=2.
// -----------------------------------------------------------------------------
module tb_led_matrix_scroller;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  char_sel;
    logic        load;
    logic        scroll_en;
    logic        scroll_dir;
`ifdef LED_MATRIX_BLINK_EN
    logic        blink_en;
`endif
    logic [15:0] row_sel;
    logic [15:0] col_data;
    logic        frame_done;
    logic        pending;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic        do_load;
        logic [2:0]  ch;
        logic        scr;
        logic        dir;
        int          nframes;
        int          chk_row;
        logic [15:0] exp_col;
    } vec_t;

    vec_t vecs[13];

    led_matrix_scroller #(
        .SIZE          (16),
        .NUM_CHARS     (6),
        .SCAN_DIV      (4),
`ifdef LED_MATRIX_BLINK_EN
        .BLINK_FRAMES  (2),
`endif
        .SCROLL_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .char_sel   (char_sel),
        .load       (load),
        .scroll_en  (scroll_en),
        .scroll_dir (scroll_dir),
`ifdef LED_MATRIX_BLINK_EN
        .blink_en   (blink_en),
`endif
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done),
        .pending    (pending)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_load(input logic [2:0] c);
        char_sel = c;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        check({name, "_frame_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_row(input int r, input string name);
        for (int i = 0; i < 200; i++) begin
            if (row_sel == (16'(1) << r)) return;
            @(negedge clk);
        end
        check({name, "_row_timeout"}, 32'(row_sel), 32'(16'(1) << r));
    endtask

    task automatic sb_check(input string name);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(col_data), 32'(e));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] er;

        //           load  ch    scr   dir   frm row  col
        vecs[0]  = '{1'b1, 3'd1, 1'b0, 1'b0, 1,  0,  16'h8000};
        vecs[1]  = '{1'b0, 3'd0, 1'b0, 1'b0, 0,  5,  16'h0400};
        vecs[2]  = '{1'b0, 3'd0, 1'b1, 1'b0, 2,  0,  16'h0001};
        vecs[3]  = '{1'b0, 3'd0, 1'b1, 1'b0, 30, 0,  16'h8000};
        vecs[4]  = '{1'b0, 3'd0, 1'b1, 1'b0, 3,  5,  16'h0800};
        vecs[5]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1,  0,  16'h8000};
        vecs[6]  = '{1'b0, 3'd0, 1'b1, 1'b1, 2,  0,  16'h4000};
        vecs[7]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3,  0,  16'h4000};
        vecs[8]  = '{1'b1, 3'd2, 1'b0, 1'b0, 1,  7,  16'hFFFF};
        vecs[9]  = '{1'b1, 3'd7, 1'b0, 1'b0, 1,  3,  16'h0000};
        vecs[10] = '{1'b1, 3'd3, 1'b0, 1'b0, 1,  2,  16'hAAAA};
        vecs[11] = '{1'b1, 3'd1, 1'b1, 1'b0, 1,  0,  16'h8000};
        vecs[12] = '{1'b0, 3'd0, 1'b1, 1'b0, 2,  1,  16'h8000};

        rst_n      = 1'b0;
        en         = 1'b1;
        char_sel   = 3'd0;
        load       = 1'b0;
        scroll_en  = 1'b0;
        scroll_dir = 1'b0;
`ifdef LED_MATRIX_BLINK_EN
        blink_en   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_row_sel",    32'(row_sel),    32'd0);
        check("rst_col_data",   32'(col_data),   32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_pending",    32'(pending),    32'd0);

        // Glyph 0 scan walk: after posedge n, row (n/4)%16 is strobed.
        rst_n = 1'b1;
        for (int n = 1; n <= 128; n++) begin
            @(negedge clk);
            er = 16'(1) << ((n / 4) % 16);
            check($sformatf("walk_row_%0d", n),  32'(row_sel),    32'(er));
            check($sformatf("walk_col_%0d", n),  32'(col_data),   32'd0);
            check($sformatf("walk_fd_%0d", n),   32'(frame_done), 32'(n % 64 == 0));
        end

        // Table-driven glyph / scroll vectors.
        for (int v = 0; v < 13; v++) begin
            scroll_en  = vecs[v].scr;
            scroll_dir = vecs[v].dir;
            if (vecs[v].do_load) begin
                pulse_load(vecs[v].ch);
                check($sformatf("vec%0d_pending_set", v), 32'(pending), 32'd1);
            end
            exp_q.push_back(vecs[v].exp_col);
            for (int f = 0; f < vecs[v].nframes; f++)
                wait_frame($sformatf("vec%0d", v));
            wait_row(vecs[v].chk_row, $sformatf("vec%0d", v));
            sb_check($sformatf("vec%0d_col", v));
            check($sformatf("vec%0d_pending_clr", v), 32'(pending), 32'd0);
        end

        // Two loads in one frame while scrolling: the last wins, and the
        // offset restarts at 0.
        pulse_load(3'd2);
        repeat (8) @(negedge clk);
        pulse_load(3'd1);
        check("dbl_pending", 32'(pending), 32'd1);
        exp_q.push_back(16'h8000);
        wait_frame("dbl");
        sb_check("dbl_row0_after_swap");
        exp_q.push_back(16'h0001);
        wait_frame("dbl2");
        wait_frame("dbl3");
        sb_check("dbl_row0_scrolled");

        // Load in the same cycle as the frame boundary.
        scroll_en = 1'b0;
        pulse_load(3'd3);
        wait_row(15, "bnd");
        repeat (3) @(negedge clk);
        char_sel = 3'd1;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        check("bnd_frame_done", 32'(frame_done), 32'd1);
        check("bnd_pending",    32'(pending),    32'd1);
        check("bnd_col_old",    32'(col_data),   32'hAAAA);
        exp_q.push_back(16'h8000);
        wait_frame("bnd2");
        sb_check("bnd_col_new");
        check("bnd_pending_clr", 32'(pending), 32'd0);

        // en low for 10 cycles mid-frame.
        wait_row(6, "en");
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("en_off_row_%0d", i), 32'(row_sel),    32'd0);
            check($sformatf("en_off_col_%0d", i), 32'(col_data),   32'd0);
            check($sformatf("en_off_fd_%0d", i),  32'(frame_done), 32'd0);
        end
        en = 1'b1;
        @(negedge clk);
        check("en_resume_row", 32'(row_sel),  32'h0040);
        check("en_resume_col", 32'(col_data), 32'h0200);
        @(negedge clk);
        check("en_hold_row",   32'(row_sel),  32'h0040);
        @(negedge clk);
        check("en_next_row",   32'(row_sel),  32'h0080);
        check("en_next_col",   32'(col_data), 32'h0100);

        // Asynchronous reset mid-scroll with a glyph pending.
        scroll_en = 1'b1;
        pulse_load(3'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_row_sel",    32'(row_sel),    32'd0);
        check("arst_col_data",   32'(col_data),   32'd0);
        check("arst_frame_done", 32'(frame_done), 32'd0);
        check("arst_pending",    32'(pending),    32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        scroll_en = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            er = 16'(1) << (n / 4);
            check($sformatf("arst_walk_row_%0d", n), 32'(row_sel),  32'(er));
            check($sformatf("arst_walk_col_%0d", n), 32'(col_data), 32'd0);
        end

`ifdef LED_MATRIX_BLINK_EN
        // Blink with BLINK_FRAMES=2: visible, blank, blank, visible.
        blink_en = 1'b1;
        pulse_load(3'd2);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hFFFF);
        for (int f = 0; f < 4; f++) begin
            wait_frame($sformatf("blink%0d", f));
            sb_check($sformatf("blink%0d_col", f));
            check($sformatf("blink%0d_row", f), 32'(row_sel), 32'h0001);
        end
        blink_en = 1'b0;
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
